// File: rtl/data_mem_be.sv
// Byte-addressed little-endian data memory for the MEM stage: byte/half/word stores, zero/sign-extending loads.
// Latency: load result, rd_valid, rd_err and wr_err are registered, visible one cycle after the access is accepted.
// Backpressure: hold freezes the load output registers, blocks commits and fault bookkeeping, and clears wr_err.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   hold                     pipeline stall
//   rd_en/rd_addr/rd_size/rd_signed   load request (size 00 byte, 01 half, 10 word, 11 illegal)
//   wr_en/wr_addr/wr_size/wr_data     store request, data right-justified
//   rd_data/rd_valid/rd_err  registered load result and status
//   wr_err                   one-cycle pulse for a faulted store
//   err_cnt/err_addr         saturating fault count and most recent fault address
//
// Optional feature macro: DMEM_BYPASS_EN -- when defined, a load to the same word as a
// same-cycle committing store returns the merged (post-store) word; otherwise read-before-write.
module data_mem_be #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_size,
    input  logic              rd_signed,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_size,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              wr_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_SAT = '1;

    // Misalignment by access size; size 11 is never legal.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    logic [31:0] mem_q [DEPTH];

    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic              wr_err_q, wr_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Address decode (word index compared at full address width so DEPTH = 2^(ADDR_W-2) fits).
    logic rd_oor, wr_oor, rd_fault, wr_fault;
    logic rd_acc, wr_acc, wr_commit;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    always_comb begin
        rd_oor    = ({2'b00, rd_addr[ADDR_W-1:2]} >= DEPTH_A);
        wr_oor    = ({2'b00, wr_addr[ADDR_W-1:2]} >= DEPTH_A);
        rd_fault  = rd_oor | misaligned(rd_size, rd_addr[1:0]);
        wr_fault  = wr_oor | misaligned(wr_size, wr_addr[1:0]);
        rd_acc    = rd_en & ~hold;
        wr_acc    = wr_en & ~hold;
        wr_commit = wr_acc & ~wr_fault;
        rd_idx    = rd_addr[IDX_W+1:2];
        wr_idx    = wr_addr[IDX_W+1:2];
    end

    // Store byte enables and lane-replicated write data.
    logic [3:0]  wr_be;
    logic [31:0] wr_wdat;

    always_comb begin
        wr_be   = 4'b0000;
        wr_wdat = wr_data;
        case (wr_size)
            2'b00: begin
                wr_be   = 4'b0001 << wr_addr[1:0];
                wr_wdat = {4{wr_data[7:0]}};
            end
            2'b01: begin
                wr_be   = wr_addr[1] ? 4'b1100 : 4'b0011;
                wr_wdat = {2{wr_data[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_wdat = wr_data;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_wdat = wr_data;
            end
        endcase
    end

    // Array is not reset; a store seen while rst_n is low must not commit.
    always_ff @(posedge clk) begin
        if (rst_n && wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_wdat[8*b +: 8];
                end
            end
        end
    end

    // Load path: fetch word, optionally merge same-cycle store, then select lane and extend.
    logic [31:0] rd_word, rd_shift, rd_ext;
    logic [15:0] rd_half;

    always_comb begin
        rd_word = mem_q[rd_idx];
`ifdef DMEM_BYPASS_EN
        if (wr_commit && (rd_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2])) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    rd_word[8*b +: 8] = wr_wdat[8*b +: 8];
                end
            end
        end
`endif
        rd_shift = rd_word >> {rd_addr[1:0], 3'b000};
        rd_half  = rd_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_size)
            2'b00:   rd_ext = {{24{rd_signed & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = {{16{rd_signed & rd_half[15]}}, rd_half};
            default: rd_ext = rd_word;
        endcase
    end

    // Next state for output registers and fault bookkeeping.
    logic [1:0]       n_flt;
    logic [CNT_W+1:0] cnt_sum;

    always_comb begin
        n_flt      = {1'b0, rd_acc & rd_fault} + {1'b0, wr_acc & wr_fault};
        cnt_sum    = {2'b00, err_cnt_q} + {{CNT_W{1'b0}}, n_flt};
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_err_d   = rd_err_q;
        wr_err_d   = 1'b0;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (!hold) begin
            rd_valid_d = rd_en;
            rd_err_d   = rd_en & rd_fault;
            rd_data_d  = (rd_en && !rd_fault) ? rd_ext : 32'h0;
            wr_err_d   = wr_en & wr_fault;
            err_cnt_d  = (cnt_sum > {2'b00, CNT_SAT}) ? CNT_SAT : cnt_sum[CNT_W-1:0];
            // Load fault wins the address capture when both fault together.
            if (rd_en && rd_fault) begin
                err_addr_d = rd_addr;
            end else if (wr_en && wr_fault) begin
                err_addr_d = wr_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be with default parameters (ADDR_W=32, DEPTH=256, CNT_W=8).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected load values for same-cycle store/load follow DMEM_BYPASS_EN.
module tb_data_mem_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_signed;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        wr_err;
    logic [7:0]  err_cnt;
    logic [31:0] err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_be #(.ADDR_W(32), .DEPTH(256), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_size   (rd_size),
        .rd_signed (rd_signed),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_size   (wr_size),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .wr_err    (wr_err),
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic en, input logic [31:0] a, input logic [1:0] sz, input logic sg);
        rd_en     = en;
        rd_addr   = a;
        rd_size   = sz;
        rd_signed = sg;
    endtask

    task automatic set_wr(input logic en, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_size = sz;
        wr_data = d;
    endtask

    task automatic idle();
        set_rd(1'b0, 32'h0, 2'b00, 1'b0);
        set_wr(1'b0, 32'h0, 2'b00, 32'h0);
    endtask

    logic [31:0] exp_bp1, exp_bp2;

    initial begin
`ifdef DMEM_BYPASS_EN
        exp_bp1 = 32'h11223344;
        exp_bp2 = 32'h11229944;
`else
        exp_bp1 = 32'hAAAAAAAA;
        exp_bp2 = 32'h11223344;
`endif
        rst_n = 1'b1;
        hold  = 1'b0;
        idle();
        #2 rst_n = 1'b0;
        // Store presented during reset must not commit.
        set_wr(1'b1, 32'h10, 2'b10, 32'hCAFEF00D);
        step(); step();
        chk("rst_rd_data",  rd_data, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_rd_err",   {31'b0, rd_err}, 32'h0);
        chk("rst_wr_err",   {31'b0, wr_err}, 32'h0);
        chk("rst_err_cnt",  {24'b0, err_cnt}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        idle();
        rst_n = 1'b1;
        step();

        // Basic stores and word load.
        set_wr(1'b1, 32'h00, 2'b10, 32'h01020304); step();
        set_wr(1'b1, 32'h04, 2'b10, 32'h55667788); step();
        set_wr(1'b1, 32'h10, 2'b10, 32'hDEADBEEF); step();
        chk("st_wr_err", {31'b0, wr_err}, 32'h0);
        idle(); set_rd(1'b1, 32'h10, 2'b10, 1'b0); step();
        chk("ldw_valid", {31'b0, rd_valid}, 32'h1);
        chk("ldw_data",  rd_data, 32'hDEADBEEF);
        chk("ldw_err",   {31'b0, rd_err}, 32'h0);

        // Byte store into lane 1, then extension checks.
        idle(); set_wr(1'b1, 32'h11, 2'b00, 32'h00000080); step();
        idle(); set_rd(1'b1, 32'h11, 2'b00, 1'b1); step();
        chk("ldb_signed", rd_data, 32'hFFFFFF80);
        set_rd(1'b1, 32'h11, 2'b00, 1'b0); step();
        chk("ldb_unsigned", rd_data, 32'h00000080);
        set_rd(1'b1, 32'h10, 2'b10, 1'b1); step();
        chk("ldw_merged", rd_data, 32'hDEAD80EF);
        set_rd(1'b1, 32'h12, 2'b01, 1'b1); step();
        chk("ldh_signed_hi", rd_data, 32'hFFFFDEAD);
        set_rd(1'b1, 32'h10, 2'b01, 1'b0); step();
        chk("ldh_unsigned_lo", rd_data, 32'h000080EF);
        idle(); step();
        chk("idle_valid", {31'b0, rd_valid}, 32'h0);
        chk("idle_data",  rd_data, 32'h0);

        // Misalignment faults.
        set_rd(1'b1, 32'h13, 2'b01, 1'b0); step();
        chk("mis_ldh_err",  {31'b0, rd_err}, 32'h1);
        chk("mis_ldh_data", rd_data, 32'h0);
        chk("mis_ldh_vld",  {31'b0, rd_valid}, 32'h1);
        chk("mis_ldh_cnt",  {24'b0, err_cnt}, 32'd1);
        chk("mis_ldh_addr", err_addr, 32'h13);
        idle(); set_wr(1'b1, 32'h06, 2'b10, 32'hFFFFFFFF); step();
        chk("mis_st_wr_err", {31'b0, wr_err}, 32'h1);
        chk("mis_st_cnt",    {24'b0, err_cnt}, 32'd2);
        chk("mis_st_addr",   err_addr, 32'h06);
        idle(); set_rd(1'b1, 32'h00, 2'b11, 1'b0); step();
        chk("sz11_err",     {31'b0, rd_err}, 32'h1);
        chk("sz11_data",    rd_data, 32'h0);
        chk("wr_err_pulse", {31'b0, wr_err}, 32'h0);
        chk("sz11_cnt",     {24'b0, err_cnt}, 32'd3);
        chk("sz11_addr",    err_addr, 32'h0);
        set_rd(1'b1, 32'h04, 2'b10, 1'b0); step();
        chk("mis_st_nochg", rd_data, 32'h55667788);

        // Out-of-range faults.
        set_rd(1'b1, 32'h400, 2'b10, 1'b0); step();
        chk("oor_ld_err",  {31'b0, rd_err}, 32'h1);
        chk("oor_ld_addr", err_addr, 32'h400);
        chk("oor_ld_cnt",  {24'b0, err_cnt}, 32'd4);
        idle(); set_wr(1'b1, 32'h400, 2'b10, 32'hFFFFFFFF); step();
        chk("oor_st_err", {31'b0, wr_err}, 32'h1);
        chk("oor_st_cnt", {24'b0, err_cnt}, 32'd5);
        idle(); set_rd(1'b1, 32'h00, 2'b10, 1'b0); step();
        chk("oor_st_nochg", rd_data, 32'h01020304);

        // Load and store faulting together: +2, load address wins.
        set_rd(1'b1, 32'h401, 2'b10, 1'b0);
        set_wr(1'b1, 32'h402, 2'b01, 32'h0000BEEF); step();
        chk("dual_cnt",    {24'b0, err_cnt}, 32'd7);
        chk("dual_addr",   err_addr, 32'h401);
        chk("dual_rd_err", {31'b0, rd_err}, 32'h1);
        chk("dual_wr_err", {31'b0, wr_err}, 32'h1);

        // Same-cycle store/load to the same word.
        idle(); set_wr(1'b1, 32'h20, 2'b10, 32'hAAAAAAAA); step();
        set_wr(1'b1, 32'h20, 2'b10, 32'h11223344);
        set_rd(1'b1, 32'h20, 2'b10, 1'b0); step();
        chk("byp_word", rd_data, exp_bp1);
        set_wr(1'b1, 32'h21, 2'b00, 32'h00000099);
        set_rd(1'b1, 32'h20, 2'b10, 1'b0); step();
        chk("byp_byte", rd_data, exp_bp2);
        idle(); set_rd(1'b1, 32'h21, 2'b00, 1'b1); step();
        chk("post_byp_byte", rd_data, 32'hFFFFFF99);

        // Load plus faulting store, then hold for 3 cycles.
        set_rd(1'b1, 32'h20, 2'b10, 1'b0);
        set_wr(1'b1, 32'h402, 2'b10, 32'h0); step();
        chk("pre_hold_data",  rd_data, 32'h11229944);
        chk("pre_hold_wrerr", {31'b0, wr_err}, 32'h1);
        chk("pre_hold_cnt",   {24'b0, err_cnt}, 32'd8);
        hold = 1'b1;
        set_wr(1'b1, 32'h20, 2'b10, 32'h5A5A5A5A);
        set_rd(1'b1, 32'h401, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold%0d_data", i),  rd_data, 32'h11229944);
            chk($sformatf("hold%0d_vld", i),   {31'b0, rd_valid}, 32'h1);
            chk($sformatf("hold%0d_rderr", i), {31'b0, rd_err}, 32'h0);
            chk($sformatf("hold%0d_wrerr", i), {31'b0, wr_err}, 32'h0);
            chk($sformatf("hold%0d_cnt", i),   {24'b0, err_cnt}, 32'd8);
            chk($sformatf("hold%0d_addr", i),  err_addr, 32'h402);
        end
        hold = 1'b0;
        idle(); set_rd(1'b1, 32'h20, 2'b10, 1'b0); step();
        chk("hold_no_commit", rd_data, 32'h11229944);

        // Counter saturation using paired faults.
        set_rd(1'b1, 32'h00, 2'b11, 1'b0);
        set_wr(1'b1, 32'h04, 2'b11, 32'h0);
        for (int i = 0; i < 123; i++) step();
        chk("cnt_254", {24'b0, err_cnt}, 32'd254);
        step();
        chk("cnt_sat", {24'b0, err_cnt}, 32'd255);
        step();
        chk("cnt_sat_hold", {24'b0, err_cnt}, 32'd255);
        chk("sat_addr", err_addr, 32'h0);

        // Asynchronous reset mid-cycle.
        idle(); set_rd(1'b1, 32'h20, 2'b10, 1'b0); step();
        chk("pre_arst_data", rd_data, 32'h11229944);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rd_data",  rd_data, 32'h0);
        chk("arst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("arst_err_cnt",  {24'b0, err_cnt}, 32'h0);
        chk("arst_err_addr", err_addr, 32'h0);
        chk("arst_rd_err",   {31'b0, rd_err}, 32'h0);
        chk("arst_wr_err",   {31'b0, wr_err}, 32'h0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
